cache_fill_arbiter: RTL and testbench

- Parametrised successor to the single-miss cache fill FSM and the memory/cache interface pair.
- Arbitrates block fills from N_REQ caches (I-cache, D-cache, future L1 ports) onto one pipelined main memory.
- Sequences BLOCK_WORDS word reads per fill and steers the returned data, word index and tag strobe to the granted cache.
- Also issues single-word write-through stores. Sits between the cache arrays and main memory.

---
 rtl/cache_fill_arbiter.sv | 156 +++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Block-fill arbiter: grants one of N_REQ cache misses, streams BLOCK_WORDS
// pipelined reads to main memory and steers returned words to the granted cache.
module cache_fill_arbiter #(
  parameter int N_REQ       = 2,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RR_ARB      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          miss_req,
  input  logic [N_REQ*ADDR_W-1:0]   miss_addr,
  input  logic                      wt_req,
  input  logic [ADDR_W-1:0]         wt_addr,
  input  logic [DATA_W-1:0]         wt_data,
  output logic                      wt_ack,
  input  logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_data_valid,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  output logic                      busy,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          stall,
  output logic [N_REQ-1:0]          write_data_array,
  output logic [N_REQ-1:0]          write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_num,
  output logic [DATA_W-1:0]         fill_data
);

  localparam int WN_W  = $clog2(BLOCK_WORDS);
  localparam int CNT_W = WN_W + 1;
  localparam int OFS   = WN_W + 1;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR = N_REQ;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFS) - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   issue_cnt;
  logic [WN_W-1:0]    recv_cnt;
  logic [IDX_W-1:0]   owner, ptr, winner;
  logic [ADDR_W-1:0]  base, base_next;
  logic               any_miss, start_fill, last_word, found;
  int unsigned        idx;

  assign stall      = miss_req;
  assign any_miss   = |miss_req;
  assign start_fill = (state == IDLE) && !wt_req && any_miss;
  assign last_word  = (state == FILL) && mem_data_valid &&
                      (recv_cnt == WN_W'(BLOCK_WORDS - 1));

  // Round-robin search starts one past the last owner, so the pointer
  // resetting to N_REQ-1 makes index 0 the first candidate.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (RR_ARB != 0) begin
      for (int unsigned off = 1; off <= NR; off++) begin
        idx = (32'(ptr) + off) % NR;
        if (!found && miss_req[idx]) begin
          winner = IDX_W'(idx);
          found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = NR; k > 0; k--) begin
        if (miss_req[k-1]) winner = IDX_W'(k - 1);
      end
    end
  end

  assign base_next = miss_addr[winner*ADDR_W +: ADDR_W] & BASE_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_fill) state_next = FILL;
      FILL: if (last_word)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      owner     <= '0;
      base      <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
    end else if (start_fill) begin
      owner     <= winner;
      base      <= base_next;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (state == FILL) begin
      if (issue_cnt < CNT_W'(BLOCK_WORDS)) issue_cnt <= issue_cnt + CNT_W'(1);
      if (mem_data_valid)                  recv_cnt  <= recv_cnt + WN_W'(1);
      if (last_word)                       ptr       <= owner;
    end
  end

  // Outputs are gated by rst so they clear asynchronously, even the
  // combinational store path in IDLE.
  always_comb begin
    wt_ack           = 1'b0;
    mem_en           = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_data_in      = '0;
    busy             = 1'b0;
    grant            = '0;
    write_data_array = '0;
    write_tag_array  = '0;
    word_num         = '0;
    fill_data        = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (wt_req) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = wt_addr;
            mem_data_in = wt_data;
            wt_ack      = 1'b1;
          end
        end
        FILL: begin
          busy         = 1'b1;
          grant[owner] = 1'b1;
          if (issue_cnt < CNT_W'(BLOCK_WORDS)) begin
            mem_en   = 1'b1;
            mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
          end
          if (mem_data_valid) begin
            write_data_array[owner] = 1'b1;
            word_num                = recv_cnt;
            fill_data               = mem_data_out;
            if (last_word) write_tag_array[owner] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: three instances (RR/8, fixed/8, RR/4)
// share stimulus; a latency-4 memory model serves whichever one is selected.
module tb_cache_fill_arbiter;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  miss_req;
  logic [31:0] miss_addr;
  logic        wt_req;
  logic [15:0] wt_addr, wt_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  int          sel;

  logic        a_wt_ack[NI], a_mem_en[NI], a_mem_wr[NI], a_busy[NI];
  logic [15:0] a_mem_addr[NI], a_mem_data_in[NI], a_fill_data[NI];
  logic [1:0]  a_grant[NI], a_stall[NI], a_wda[NI], a_wta[NI];
  logic [2:0]  a_wn[NI];

  logic        wt_ack, mem_en, mem_wr, busy;
  logic [15:0] mem_addr, mem_data_in, fill_data;
  logic [1:0]  grant, stall, wda, wta;
  logic [2:0]  wn;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BW = (g == 2) ? 4 : 8;
    localparam int RR = (g == 1) ? 0 : 1;
    logic [$clog2(BW)-1:0] wn_local;
    cache_fill_arbiter #(.N_REQ(2), .BLOCK_WORDS(BW), .ADDR_W(16), .DATA_W(16), .RR_ARB(RR)) u_dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .wt_req(wt_req), .wt_addr(wt_addr), .wt_data(wt_data), .wt_ack(a_wt_ack[g]),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .mem_en(a_mem_en[g]), .mem_wr(a_mem_wr[g]), .mem_addr(a_mem_addr[g]),
      .mem_data_in(a_mem_data_in[g]), .busy(a_busy[g]), .grant(a_grant[g]),
      .stall(a_stall[g]), .write_data_array(a_wda[g]), .write_tag_array(a_wta[g]),
      .word_num(wn_local), .fill_data(a_fill_data[g]));
    assign a_wn[g] = 3'(wn_local);
  end

  always_comb begin
    wt_ack = a_wt_ack[sel];   mem_en = a_mem_en[sel];     mem_wr = a_mem_wr[sel];
    busy = a_busy[sel];       mem_addr = a_mem_addr[sel]; mem_data_in = a_mem_data_in[sel];
    fill_data = a_fill_data[sel]; grant = a_grant[sel];   stall = a_stall[sel];
    wda = a_wda[sel];         wta = a_wta[sel];           wn = a_wn[sel];
  end

  // Memory returns addr ^ 0xA5A5 four cycles after a read is issued; it is
  // deliberately not flushed by rst.
  logic [16:0] pipe[4];
  initial for (int k = 0; k < 4; k++) pipe[k] = '0;
  always @(posedge clk) begin
    pipe[0] <= {mem_en && !mem_wr, mem_addr ^ 16'hA5A5};
    for (int k = 3; k > 0; k--) pipe[k] <= pipe[k-1];
  end
  assign mem_data_valid = pipe[3][16];
  assign mem_data_out   = pipe[3][15:0];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  miss;
    logic        en;
    logic [15:0] addr;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  wda;
    logic [1:0]  wta;
    logic [2:0]  wn;
  } vec_t;

  function automatic vec_t mk(logic [1:0] m, logic e, logic [15:0] a, logic [1:0] g,
                              logic b, logic [1:0] d, logic [1:0] t, logic [2:0] w);
    vec_t v;
    v.miss = m; v.en = e; v.addr = a; v.grant = g; v.busy = b; v.wda = d; v.wta = t; v.wn = w;
    return v;
  endfunction

  task automatic do_reset(input int s);
    @(negedge clk);
    sel = s; rst = 1'b1; miss_req = '0; wt_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Follows one fill from the cycle after the call until its tag strobe,
  // returning in the tag-strobe cycle so the caller can drop the miss there.
  task automatic fill_observe(input string tag, input logic [1:0] exp_g, input logic [15:0] exp_base,
                              input int exp_wait, input int exp_words);
    int waited = 0, issued = 0, recvd = 0, errs = 0;
    bit done = 1'b0;
    do begin
      @(negedge clk); #1; waited++;
    end while (!busy && waited < 40);
    chk({tag, " start latency"}, waited, exp_wait);
    chk({tag, " grant"}, grant, exp_g);
    for (int c = 0; c < 80 && !done; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (mem_en) begin
        if (mem_wr || mem_addr !== exp_base + 16'(2 * issued)) errs++;
        issued++;
      end
      if (grant !== exp_g || !busy) errs++;
      if (wda != 0) begin
        if (wda !== exp_g || 32'(wn) !== recvd ||
            fill_data !== ((exp_base + 16'(2 * recvd)) ^ 16'hA5A5)) errs++;
        recvd++;
      end
      if (wta != 0) begin
        chk({tag, " tag strobe"}, wta, exp_g);
        done = 1'b1;
      end
    end
    chk({tag, " tag seen"}, done, 1);
    chk({tag, " reads issued"}, issued, exp_words);
    chk({tag, " words received"}, recvd, exp_words);
    chk({tag, " per-cycle errors"}, errs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    int   cnt, errs;
    logic [15:0] fd;

    rst = 1'b1; sel = 0; miss_req = '0; miss_addr = '0;
    wt_req = 1'b0; wt_addr = '0; wt_data = '0;

    #12;
    chk("reset grant", grant, 0);     chk("reset busy", busy, 0);
    chk("reset mem_en", mem_en, 0);   chk("reset mem_wr", mem_wr, 0);
    chk("reset wt_ack", wt_ack, 0);   chk("reset wda", wda, 0);
    chk("reset wta", wta, 0);         chk("reset word_num", wn, 0);

    // I-miss at 0x0046: reads 0x40..0x4E on cycles 1..8, data on 5..12
    tbl[0]  = mk(2'b01, 0, 16'h0000, 2'b00, 0, 2'b00, 2'b00, 0);
    tbl[1]  = mk(2'b01, 1, 16'h0040, 2'b01, 1, 2'b00, 2'b00, 0);
    tbl[2]  = mk(2'b01, 1, 16'h0042, 2'b01, 1, 2'b00, 2'b00, 0);
    tbl[3]  = mk(2'b01, 1, 16'h0044, 2'b01, 1, 2'b00, 2'b00, 0);
    tbl[4]  = mk(2'b01, 1, 16'h0046, 2'b01, 1, 2'b00, 2'b00, 0);
    tbl[5]  = mk(2'b01, 1, 16'h0048, 2'b01, 1, 2'b01, 2'b00, 0);
    tbl[6]  = mk(2'b01, 1, 16'h004A, 2'b01, 1, 2'b01, 2'b00, 1);
    tbl[7]  = mk(2'b01, 1, 16'h004C, 2'b01, 1, 2'b01, 2'b00, 2);
    tbl[8]  = mk(2'b01, 1, 16'h004E, 2'b01, 1, 2'b01, 2'b00, 3);
    tbl[9]  = mk(2'b01, 0, 16'h0000, 2'b01, 1, 2'b01, 2'b00, 4);
    tbl[10] = mk(2'b01, 0, 16'h0000, 2'b01, 1, 2'b01, 2'b00, 5);
    tbl[11] = mk(2'b01, 0, 16'h0000, 2'b01, 1, 2'b01, 2'b00, 6);
    tbl[12] = mk(2'b01, 0, 16'h0000, 2'b01, 1, 2'b01, 2'b01, 7);
    tbl[13] = mk(2'b00, 0, 16'h0000, 2'b00, 0, 2'b00, 2'b00, 0);

    do_reset(0);
    miss_addr = {16'h0000, 16'h0046};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      miss_req = tbl[i].miss;
      #1;
      chk($sformatf("v%0d mem_en", i), mem_en, tbl[i].en);
      chk($sformatf("v%0d mem_wr", i), mem_wr, 0);
      chk($sformatf("v%0d grant", i), grant, tbl[i].grant);
      chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d stall", i), stall, tbl[i].miss);
      chk($sformatf("v%0d wda", i), wda, tbl[i].wda);
      chk($sformatf("v%0d wta", i), wta, tbl[i].wta);
      if (tbl[i].en) chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].wda != 0) begin
        fd = (16'h0040 + 16'({tbl[i].wn, 1'b0})) ^ 16'hA5A5;
        chk($sformatf("v%0d word_num", i), wn, tbl[i].wn);
        chk($sformatf("v%0d fill_data", i), fill_data, fd);
      end
    end

    // Round robin with both misses held: 0, 1, 0
    do_reset(0);
    miss_addr = {16'h0206, 16'h0100};
    @(negedge clk); miss_req = 2'b11;
    fill_observe("rr first", 2'b01, 16'h0100, 1, 8);
    fill_observe("rr second", 2'b10, 16'h0200, 2, 8);
    fill_observe("rr third", 2'b01, 16'h0100, 2, 8);
    miss_req = '0;

    // Fixed priority: index 0 wins twice, then 1 once 0 is dropped
    do_reset(1);
    @(negedge clk); miss_req = 2'b11;
    fill_observe("fp first", 2'b01, 16'h0100, 1, 8);
    fill_observe("fp second", 2'b01, 16'h0100, 2, 8);
    miss_req = 2'b10;
    fill_observe("fp third", 2'b10, 16'h0200, 2, 8);
    miss_req = '0;

    // Store in IDLE beats a simultaneous D-miss
    do_reset(0);
    miss_addr = {16'h0400, 16'h0000};
    @(negedge clk);
    miss_req = 2'b10; wt_req = 1'b1; wt_addr = 16'h1234; wt_data = 16'hBEEF;
    #1;
    chk("wt mem_en", mem_en, 1);       chk("wt mem_wr", mem_wr, 1);
    chk("wt mem_addr", mem_addr, 16'h1234);
    chk("wt mem_data_in", mem_data_in, 16'hBEEF);
    chk("wt ack", wt_ack, 1);          chk("wt busy", busy, 0);
    @(negedge clk); wt_req = 1'b0; #1;
    chk("wt after ack", wt_ack, 0);    chk("wt arb cycle mem_en", mem_en, 0);
    fill_observe("wt dmiss", 2'b10, 16'h0400, 1, 8);
    miss_req = '0;

    // Store raised mid-fill waits until the IDLE cycle after the tag strobe
    do_reset(0);
    miss_addr = {16'h0000, 16'h0500};
    @(negedge clk); miss_req = 2'b01;
    cnt = 0;
    do begin @(negedge clk); #1; cnt++; end while (!busy && cnt < 40);
    wt_req = 1'b1; wt_addr = 16'h2222; wt_data = 16'h1111;
    errs = 0; cnt = 0;
    do begin
      @(negedge clk); #1; cnt++;
      if (wt_ack) errs++;
    end while (wta == 0 && cnt < 40);
    chk("midfill tag seen", wta, 2'b01);
    chk("midfill wt_ack held low", errs, 0);
    miss_req = '0;
    @(negedge clk); #1;
    chk("midfill wt_ack", wt_ack, 1);  chk("midfill mem_wr", mem_wr, 1);
    chk("midfill mem_addr", mem_addr, 16'h2222);
    chk("midfill mem_data_in", mem_data_in, 16'h1111);
    wt_req = 1'b0;

    // Reset after three words: outputs clear at once, late data ignored
    do_reset(0);
    miss_addr = {16'h0000, 16'h0300};
    @(negedge clk); miss_req = 2'b01;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 3; c++) begin
      @(negedge clk); #1;
      if (wda != 0) cnt++;
    end
    chk("rst words before", cnt, 3);
    rst = 1'b1; miss_req = '0;
    #1;
    chk("rst async grant", grant, 0);  chk("rst async busy", busy, 0);
    chk("rst async mem_en", mem_en, 0);
    chk("rst async wda", wda, 0);      chk("rst async wta", wta, 0);
    @(negedge clk); rst = 1'b0;
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (wda != 0 || wta != 0 || busy || mem_en) errs++;
    end
    chk("rst stale data ignored", errs, 0);
    @(negedge clk); miss_req = 2'b01;
    fill_observe("rst restart", 2'b01, 16'h0300, 1, 8);
    miss_req = '0;

    // BLOCK_WORDS=4 at the top of the address space
    do_reset(2);
    miss_addr = {16'h0000, 16'hFFFE};
    @(negedge clk); miss_req = 2'b01;
    fill_observe("b4 top", 2'b01, 16'hFFF8, 1, 4);
    miss_req = '0;
    @(negedge clk); #1;
    chk("b4 idle after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
